compose_collect: RTL

Downstream consumer of the inverting register chain: takes the chain's 1-bit output plus the valid bit that accompanied the chain's input. It re-aligns valid to the chain latency, undoes net inversion, and assembles WIDTH bits LSB-first into a word. Each word is presented on a valid/ready output with a single holding register and a sticky overflow flag. This turns the bit-serial chain into a word stream for the STV composition regression.

---
 rtl/compose_pkg.sv | 18 +
 rtl/compose_valid_delay.sv | 40 ++++
 rtl/compose_collect.sv | 114 +++++++++++
 3 files changed

// File: rtl/compose_pkg.sv
`default_nettype none
// ============================================================================
// Module   : compose_pkg
// Brief    : Shared defaults and helpers for the bit-serial word collector.
// Revision : 1.0 - initial release
// ============================================================================
package compose_pkg;

    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_WIDTH = 8;

    // Net inversion of a chain whose every stage inverts.
    function automatic bit chain_invert(input int depth);
        return (depth % 2) != 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/compose_valid_delay.sv
`default_nettype none
// ============================================================================
// Module   : compose_valid_delay
// Brief    : DEPTH-stage reset-to-0 shift line tracking the chain latency.
// Revision : 1.0 - initial release
// ============================================================================
module compose_valid_delay
    import compose_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = i_din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_dout = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/compose_collect.sv
`default_nettype none
// ============================================================================
// Module   : compose_collect
// Brief    : Assembles the inverting chain's serial output into LSB-first
//            words behind a single valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module compose_collect
    import compose_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             chain_q,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic               w_aligned;
    logic               w_bit;
    logic [WIDTH-1:0]   w_word;
    logic               w_complete;
    logic               w_ovf_set;

    // Only the upper WIDTH-1 bits of the shift register are ever consumed.
    logic [WIDTH-2:0]   sr_q,        sr_d;
    logic [c_CNT_W-1:0] cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               overflow_q,  overflow_d;

    compose_valid_delay #(
        .DEPTH  (DEPTH)
    ) u_valid_delay (
        .clk    (clk),
        .rst    (rst),
        .i_din  (in_valid),
        .o_dout (w_aligned)
    );

    assign w_bit  = chain_q ^ INVERT;
    assign w_word = {w_bit, sr_q};

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        w_complete  = 1'b0;
        w_ovf_set   = 1'b0;

        if (w_aligned) begin
            if (cnt_q == c_CNT_LAST) begin
                cnt_d      = '0;
                w_complete = 1'b1;
            end else begin
                sr_d  = w_word[WIDTH-1:1];
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Accept and completion in one cycle reloads the slot, keeping full rate.
        if (w_complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = w_word;
                out_valid_d = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire
